// File: rtl/gyro_pkg.sv
// Shared constants, command encodings and state enums for the PmodGyro
// (L3G4200D) SPI reader and its shift engine.
package gyro_pkg;

    // L3G4200D register addresses
    localparam logic [7:0] CTRL_REG1 = 8'h20;
    localparam logic [7:0] OUT_TEMP  = 8'h26;
    localparam logic [7:0] OUT_X_L   = 8'h28;

    // Command byte bits: read, and multi-byte auto-increment
    localparam logic [7:0] RD = 8'h80;
    localparam logic [7:0] MS = 8'h40;

    // Width of the per-frame bit count (up to 72 bits)
    localparam int XFER_CNT_W = 7;

    // Bits the engine shifts out: the command byte plus one data byte
    localparam int TX_W = 16;

    typedef enum logic [2:0] {
        S_INIT_CS,
        S_INIT_XFER,
        S_INIT_HOLD,
        S_WAIT,
        S_READ_CS,
        S_READ_XFER,
        S_READ_HOLD,
        S_UPDATE
    } gyro_state_e;

    typedef enum logic [2:0] {
        E_IDLE,
        E_SETUP,
        E_LOW,
        E_HIGH,
        E_HOLD,
        E_GAP1,
        E_GAP2
    } eng_state_e;

    function automatic logic [7:0] burst_read_cmd(input logic [7:0] addr);
        return RD | MS | addr;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-3 shift engine: owns SCLK generation and ss setup/hold/gap timing.
// Ports: clk, rst (sync, active-high); start/busy/done handshake (done is a
//   one-cycle pulse); n_bits = frame length; tx_data is shifted out MSB first,
//   then zeros; rx_data collects MISO, most recent bit in the LSB;
//   sclk/mosi/ss drive the bus.
// Frame: ss low one half-period before the first falling edge, N SCLK periods,
// a trailing half-period, then ss high for two half-periods; done fires after
// the first of those two.
module spi_shift_engine
    import gyro_pkg::*;
#(
    parameter int CLKS_PER_HALF_SCLK = 50,
    parameter int RX_W               = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [XFER_CNT_W-1:0] n_bits,
    input  logic [TX_W-1:0]       tx_data,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  ss,
    output logic                  busy,
    output logic                  done,
    output logic [RX_W-1:0]       rx_data
);

    localparam int HW = $clog2(CLKS_PER_HALF_SCLK);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_SCLK - 1);

    eng_state_e            state_q, state_d;
    logic [HW-1:0]         cnt_q, cnt_d;
    logic [XFER_CNT_W-1:0] bits_q, bits_d;
    logic [TX_W-1:0]       tx_q, tx_d;
    logic [RX_W-1:0]       rx_q, rx_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  ss_q, ss_d;
    logic                  done_q, done_d;

    logic half_end;
    logic fall;
    logic rise;

    assign half_end = (state_q != E_IDLE) && (cnt_q == HALF_LAST);
    // bits_q counts falling edges still owed; zero at the end of HIGH
    // means the final period has just completed.
    assign fall = half_end && ((state_q == E_SETUP) ||
                  ((state_q == E_HIGH) && (bits_q != '0)));
    assign rise = half_end && (state_q == E_LOW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= E_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            ss_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ss_q    <= ss_d;
            done_q  <= done_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            E_IDLE:  if (start)    state_d = E_SETUP;
            E_SETUP: if (half_end) state_d = E_LOW;
            E_LOW:   if (half_end) state_d = E_HIGH;
            E_HIGH:  if (half_end) state_d = (bits_q == '0) ? E_HOLD : E_LOW;
            E_HOLD:  if (half_end) state_d = E_GAP1;
            E_GAP1:  if (half_end) state_d = E_GAP2;
            E_GAP2:  if (half_end) state_d = E_IDLE;
            default:               state_d = E_IDLE;
        endcase
    end

    always_comb begin : datapath
        cnt_d  = (state_q == E_IDLE || half_end) ? '0 : cnt_q + 1'b1;
        bits_d = bits_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        ss_d   = ss_q;
        done_d = 1'b0;

        if (state_q == E_IDLE && start) begin
            ss_d   = 1'b0;
            sclk_d = 1'b1;
            mosi_d = 1'b0;
            bits_d = n_bits;
            tx_d   = tx_data;
        end
        if (fall) begin
            sclk_d = 1'b0;
            mosi_d = tx_q[TX_W-1];
            tx_d   = {tx_q[TX_W-2:0], 1'b0};
            bits_d = bits_q - 1'b1;
        end
        if (rise) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[RX_W-2:0], miso};
        end
        if (half_end && state_q == E_HIGH && bits_q == '0) begin
            mosi_d = 1'b0;
        end
        if (half_end && state_q == E_HOLD) begin
            ss_d = 1'b1;
        end
        if (half_end && state_q == E_GAP1) begin
            done_d = 1'b1;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss      = ss_q;
    assign busy    = (state_q != E_IDLE);
    assign done    = done_q;
    assign rx_data = rx_q;

endmodule

// File: rtl/gyro_spi_reader.sv
// PmodGyro reader: writes CTRL_REG1 once after reset, then burst-reads
// X/Y/Z (and optionally OUT_TEMP) every SAMPLE_PERIOD clocks.
// Ports: clk, rst (sync, active-high); enable gates sample ticks;
//   miso/sclk/mosi/ss form the SPI mode-3 bus; x_axis/y_axis/z_axis are
//   {H,L} rate words; temp is OUT_TEMP; data_valid pulses for one clk when
//   all outputs update; init_done stays high once configuration is done.
// Build option: define GYRO_TEMP_EN to also read OUT_TEMP and STATUS_REG;
//   without it temp is tied to zero.
module gyro_spi_reader
    import gyro_pkg::*;
#(
    parameter int         CLKS_PER_HALF_SCLK = 50,
    parameter int         SAMPLE_PERIOD      = 1000000,
    parameter logic [7:0] CTRL1_VALUE        = 8'h0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        ss,
    output logic [15:0] x_axis,
    output logic [15:0] y_axis,
    output logic [15:0] z_axis,
    output logic [7:0]  temp,
    output logic        data_valid,
    output logic        init_done
);

`ifdef GYRO_TEMP_EN
    localparam int         RX_W     = 64;
    localparam logic [7:0] READ_CMD = burst_read_cmd(OUT_TEMP);
`else
    localparam int         RX_W     = 48;
    localparam logic [7:0] READ_CMD = burst_read_cmd(OUT_X_L);
`endif

    localparam logic [XFER_CNT_W-1:0] INIT_BITS = XFER_CNT_W'(16);
    localparam logic [XFER_CNT_W-1:0] READ_BITS = XFER_CNT_W'(8 + RX_W);

    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    gyro_state_e      state_q, state_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             pending_q, pending_d;
    logic             init_done_q, init_done_d;
    logic             dv_q, dv_d;
    logic [15:0]      x_q, x_d;
    logic [15:0]      y_q, y_d;
    logic [15:0]      z_q, z_d;
    logic [7:0]       temp_q, temp_d;

    logic                  eng_start;
    logic [XFER_CNT_W-1:0] eng_bits;
    logic [TX_W-1:0]       eng_tx;
    logic                  eng_busy;
    logic                  eng_done;
    logic [RX_W-1:0]       eng_rx;

    logic tick;
    logic in_read;
    logic latch;

    spi_shift_engine #(
        .CLKS_PER_HALF_SCLK (CLKS_PER_HALF_SCLK),
        .RX_W               (RX_W)
    ) u_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (eng_start),
        .n_bits  (eng_bits),
        .tx_data (eng_tx),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss      (ss),
        .busy    (eng_busy),
        .done    (eng_done),
        .rx_data (eng_rx)
    );

    // Free-running sample timebase, held at zero until configuration is done
    assign tick    = init_done_q && (period_q == PER_LAST);
    assign in_read = state_q inside {S_READ_CS, S_READ_XFER,
                                     S_READ_HOLD, S_UPDATE};
    assign latch   = (state_q == S_READ_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT_CS;
            period_q    <= '0;
            pending_q   <= 1'b0;
            init_done_q <= 1'b0;
            dv_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            temp_q      <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            pending_q   <= pending_d;
            init_done_q <= init_done_d;
            dv_q        <= dv_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            temp_q      <= temp_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            S_INIT_CS:   if (!eng_busy) state_d = S_INIT_XFER;
            S_INIT_XFER: if (eng_done)  state_d = S_INIT_HOLD;
            S_INIT_HOLD:                state_d = S_WAIT;
            S_WAIT: begin
                if ((tick || pending_q) && enable) state_d = S_READ_CS;
            end
            S_READ_CS:   if (!eng_busy) state_d = S_READ_XFER;
            S_READ_XFER: if (eng_done)  state_d = S_READ_HOLD;
            S_READ_HOLD:                state_d = S_UPDATE;
            S_UPDATE:                   state_d = S_WAIT;
            default:                    state_d = S_INIT_CS;
        endcase
    end

    always_comb begin : outputs
        eng_start = 1'b0;
        eng_bits  = INIT_BITS;
        eng_tx    = {CTRL_REG1, CTRL1_VALUE};
        if (state_q == S_INIT_CS) begin
            eng_start = 1'b1;
        end
        if (state_q == S_READ_CS) begin
            eng_start = 1'b1;
            eng_bits  = READ_BITS;
            eng_tx    = {READ_CMD, 8'h00};
        end

        period_d    = (!init_done_q || tick) ? '0 : period_q + 1'b1;
        init_done_d = init_done_q || (state_q == S_INIT_HOLD);

        // One-deep: a tick during a read is remembered once; S_WAIT always
        // clears it, whether the read is started or enable discards it.
        pending_d = pending_q;
        if (state_q == S_WAIT) begin
            pending_d = 1'b0;
        end else if (tick && in_read) begin
            pending_d = 1'b1;
        end

        // Load on the edge into S_UPDATE so data_valid and new data coincide
        dv_d = latch;
        x_d  = latch ? {eng_rx[39:32], eng_rx[47:40]} : x_q;
        y_d  = latch ? {eng_rx[23:16], eng_rx[31:24]} : y_q;
        z_d  = latch ? {eng_rx[7:0],   eng_rx[15:8]}  : z_q;
`ifdef GYRO_TEMP_EN
        temp_d = latch ? eng_rx[63:56] : temp_q;
`else
        temp_d = 8'h00;
`endif
    end

    assign x_axis     = x_q;
    assign y_axis     = y_q;
    assign z_axis     = z_q;
    assign temp       = temp_q;
    assign data_valid = dv_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_gyro_spi_reader.sv
// Directed bench for gyro_spi_reader with an SPI mode-3 gyro slave model.
// Runs with a 2-clk SCLK half-period and a 100-clk sample period.
`timescale 1ns/1ps
module tb_gyro_spi_reader;

    localparam int H  = 2;
    localparam int SP = 100;

`ifdef GYRO_TEMP_EN
    localparam int          NB       = 72;
    localparam logic [7:0]  EXP_CMD  = 8'hE6;
    localparam logic [7:0]  EXP_TEMP = 8'h19;
    localparam logic [71:0] SLV_DATA = {8'h00, 8'h19, 8'h0F,
        8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
`else
    localparam int          NB       = 56;
    localparam logic [7:0]  EXP_CMD  = 8'hE8;
    localparam logic [7:0]  EXP_TEMP = 8'h00;
    localparam logic [71:0] SLV_DATA = {8'h00,
        8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 16'h0000};
`endif

    localparam int INIT_LOW = 34 * H;
    localparam int DV_LAT   = (2 + 2 * NB + 1) * H + 2;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        miso = 1'b0;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic [15:0] x_axis;
    logic [15:0] y_axis;
    logic [15:0] z_axis;
    logic [7:0]  temp;
    logic        data_valid;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    gyro_spi_reader #(
        .CLKS_PER_HALF_SCLK (H),
        .SAMPLE_PERIOD      (SP),
        .CTRL1_VALUE        (8'h0F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .miso       (miso),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss         (ss),
        .x_axis     (x_axis),
        .y_axis     (y_axis),
        .z_axis     (z_axis),
        .temp       (temp),
        .data_valid (data_valid),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor and slave, sampled on the falling clk edge
    int          cyc = 0;
    int          frames = 0;
    int          cur_bits = 0;
    int          cur_start = 0;
    logic [71:0] cur_mosi = '0;
    int          rec_bits = 0;
    int          rec_start = 0;
    int          rec_low = 0;
    logic [71:0] rec_mosi = '0;
    int          last_rise = 0;
    int          last_gap = 0;
    int          dv_pulses = 0;
    int          dv_high = 0;
    int          dv_cyc = 0;
    int          id_cyc = 0;
    logic        init_at_rise = 1'b0;
    logic [71:0] slv_sh = '0;
    logic        ss_p = 1'b1;
    logic        sclk_p = 1'b1;
    logic        dv_p = 1'b0;
    logic        id_p = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ss_p === 1'b1 && ss === 1'b0) begin
            cur_bits  = 0;
            cur_mosi  = '0;
            cur_start = cyc;
            slv_sh    = SLV_DATA;
            if (frames > 0) last_gap = cyc - last_rise;
        end
        if (ss === 1'b0 && sclk_p === 1'b1 && sclk === 1'b0) begin
            miso   = slv_sh[71];
            slv_sh = {slv_sh[70:0], 1'b0};
        end
        if (ss === 1'b0 && sclk_p === 1'b0 && sclk === 1'b1) begin
            cur_mosi = {cur_mosi[70:0], mosi};
            cur_bits = cur_bits + 1;
        end
        if (ss_p === 1'b0 && ss === 1'b1) begin
            rec_bits     = cur_bits;
            rec_mosi     = cur_mosi;
            rec_start    = cur_start;
            rec_low      = cyc - cur_start;
            init_at_rise = init_done;
            last_rise    = cyc;
            frames       = frames + 1;
        end
        if (data_valid === 1'b1) begin
            dv_high = dv_high + 1;
            if (dv_p !== 1'b1) begin
                dv_pulses = dv_pulses + 1;
                dv_cyc    = cyc;
            end
        end
        if (init_done === 1'b1 && id_p !== 1'b1) id_cyc = cyc;
        ss_p   = ss;
        sclk_p = sclk;
        dv_p   = data_valid;
        id_p   = init_done;
    end

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (frames < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 72'(frames >= n), 72'(1));
    endtask

    int en_cyc;
    int exp_start;
    int k;

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) step();

        check("rst_ss", 72'(ss), 72'(1));
        check("rst_sclk", 72'(sclk), 72'(1));
        check("rst_mosi", 72'(mosi), 72'(0));
        check("rst_x", 72'(x_axis), 72'(0));
        check("rst_y", 72'(y_axis), 72'(0));
        check("rst_z", 72'(z_axis), 72'(0));
        check("rst_temp", 72'(temp), 72'(0));
        check("rst_dv", 72'(data_valid), 72'(0));
        check("rst_init_done", 72'(init_done), 72'(0));

        rst = 1'b0;
        wait_frames(1, 500, "init_frame_seen");
        check("init_bits", 72'(rec_bits), 72'(16));
        check("init_mosi", 72'(rec_mosi[15:0]), 72'(16'h200F));
        check("init_ss_low", 72'(rec_low), 72'(INIT_LOW));
        check("init_done_at_ss_rise", 72'(init_at_rise), 72'(0));
        k = 0;
        while (init_done !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        check("init_done_rise", 72'(init_done), 72'(1));

        // enable low across three ticks: bus stays quiet
        repeat (350) step();
        check("idle_frames", 72'(frames), 72'(1));
        check("idle_dv", 72'(dv_pulses), 72'(0));
        check("idle_x", 72'(x_axis), 72'(0));

        en_cyc = cyc;
        enable = 1'b1;
        exp_start = id_cyc + SP - 1;
        while (exp_start < en_cyc) exp_start += SP;
        exp_start += 2;

        wait_frames(2, 600, "read_frame_seen");
        check("read_start_cycle", 72'(rec_start), 72'(exp_start));
        check("read_bits", 72'(rec_bits), 72'(NB));
        check("read_cmd", 72'(rec_mosi[NB-1 -: 8]), 72'(EXP_CMD));
        check("read_mosi_zero", 72'(rec_mosi[NB-9:0]), 72'(0));
        k = 0;
        while (dv_pulses < 1 && k < 50) begin
            step();
            k++;
        end
        check("dv_seen", 72'(dv_pulses), 72'(1));
        check("dv_latency", 72'(dv_cyc - rec_start), 72'(DV_LAT));
        check("x_axis", 72'(x_axis), 72'(16'h1234));
        check("y_axis", 72'(y_axis), 72'(16'h5678));
        check("z_axis", 72'(z_axis), 72'(16'h9ABC));
        check("temp", 72'(temp), 72'(EXP_TEMP));
        step();
        check("dv_width", 72'(dv_high), 72'(1));

        // Sample period shorter than a read: pending tick chains reads
        wait_frames(4, 1000, "b2b_frames");
        check("b2b_bits", 72'(rec_bits), 72'(NB));
        check("b2b_dv_count", 72'(dv_pulses), 72'(2));
        check("b2b_gap_min", 72'(last_gap >= 2 * H), 72'(1));
        check("b2b_gap_prompt", 72'(last_gap <= 2 * H + 8), 72'(1));
        check("b2b_x_hold", 72'(x_axis), 72'(16'h1234));

        // Reset in the middle of the next read, after bit 20
        k = 0;
        while (!(frames == 4 && ss === 1'b0 && cur_bits >= 20) && k < 600) begin
            step();
            k++;
        end
        check("mid_read_reached", 72'(cur_bits), 72'(20));
        rst = 1'b1;
        step();
        check("mrst_ss", 72'(ss), 72'(1));
        check("mrst_sclk", 72'(sclk), 72'(1));
        check("mrst_x", 72'(x_axis), 72'(0));
        check("mrst_y", 72'(y_axis), 72'(0));
        check("mrst_z", 72'(z_axis), 72'(0));
        check("mrst_dv", 72'(data_valid), 72'(0));
        check("mrst_init_done", 72'(init_done), 72'(0));
        rst = 1'b0;
        check("abort_bits", 72'(rec_bits), 72'(20));

        wait_frames(6, 500, "reinit_frame_seen");
        check("reinit_bits", 72'(rec_bits), 72'(16));
        check("reinit_mosi", 72'(rec_mosi[15:0]), 72'(16'h200F));
        check("reinit_x", 72'(x_axis), 72'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
